// File: rtl/hardwired_control_unit.sv
// hardwired_control_unit
// Moore control sequencer for a single-bus datapath: fetch, 3-register ALU
// ops, mul/div through HI/LO, nop and halt. Every output is a function of
// the current state and the IR fields only; the state register is the only
// storage in the block.
//
// Optional build macro MEM_WAIT_EN: adds a mem_ready input and a fetch wait
// state F1W that holds Read/MDRin until memory responds.
//
// The IR fields are sampled for decode on the way out of F2, so the
// instruction being fetched must be visible on ir by the end of F2.
module hardwired_control_unit #(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
`ifdef MEM_WAIT_EN
    input  logic            mem_ready,
`endif
    output logic            PCout,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            MDRout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            ZlowIn,
    output logic            ZhighIn,
    output logic            Read,
    output logic            IncPC,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [OPW-1:0]  alu_op,
    output logic            run
);

    typedef enum logic [3:0] {
        RESET_ST,
        F0,
        F1,
`ifdef MEM_WAIT_EN
        F1W,
`endif
        F2,
        T3,
        T4,
        T5,
        T6,
        HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ALU_LO = OPW'(3);
    localparam logic [OPW-1:0] OP_ALU_HI = OPW'(14);
    localparam logic [OPW-1:0] OP_MUL    = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV    = OPW'(16);
    localparam logic [OPW-1:0] OP_HALT   = OPW'(27);

    state_t state_q, state_d;

    logic [OPW-1:0] op;
    logic [3:0]     ra, rb, rc;
    logic           is_alu, is_muldiv;
    logic           ir_unused;

    assign op        = ir[31 -: OPW];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign ir_unused = ^ir[14:0];

    assign is_alu    = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State register; clear drops the sequencer back to RESET_ST at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= RESET_ST;
        else       state_q <= state_d;
    end

    // Next-state decode and Moore strobes for the current state.
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ZlowIn   = 1'b0;
        ZhighIn  = 1'b0;
        Read     = 1'b0;
        IncPC    = 1'b0;
        Rin      = '0;
        Rout     = '0;
        alu_op   = '0;
        run      = 1'b0;

        case (state_q)
            RESET_ST: begin
                state_d = F0;
            end
            F0: begin
                // PC to MAR while the ALU forms PC+1 into Z.
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZlowIn  = 1'b1;
                alu_op  = '1;
                run     = 1'b1;
                state_d = F1;
            end
            F1: begin
                // PC+1 back into PC, memory word into MDR.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                run     = 1'b1;
`ifdef MEM_WAIT_EN
                state_d = mem_ready ? F2 : F1W;
`else
                state_d = F2;
`endif
            end
`ifdef MEM_WAIT_EN
            F1W: begin
                // PC already updated; keep the read open until memory answers.
                Read    = 1'b1;
                MDRin   = 1'b1;
                run     = 1'b1;
                state_d = mem_ready ? F2 : F1W;
            end
`endif
            F2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                run    = 1'b1;
                if (is_alu || is_muldiv) state_d = T3;
                else if (op == OP_HALT)  state_d = HALT;
                else                     state_d = F0;
            end
            T3: begin
                Rout    = onehot(rb);
                Yin     = 1'b1;
                run     = 1'b1;
                state_d = T4;
            end
            T4: begin
                Rout    = onehot(rc);
                alu_op  = op;
                ZlowIn  = 1'b1;
                ZhighIn = is_muldiv;
                run     = 1'b1;
                state_d = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                run     = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    Rin     = onehot(ra);
                    state_d = F0;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                run      = 1'b1;
                state_d  = F0;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RESET_ST;
            end
        endcase
    end

endmodule
